// File: rtl/stack_unit_param.sv
// LIFO stack of DEPTH x WIDTH words behind a rdy/ack request handshake.
// Every request takes the same four-state path IDLE -> EXEC -> MEM -> DONE.
module stack_unit_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rdy_in,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] datain,
    input  logic [AW-1:0]    n,
    output logic             ack_out,
    output logic             rdy_out,
    output logic [WIDTH-1:0] dataout,
    output logic             esito,
    output logic             full,
    output logic             empty,
    output logic [1:0]       state_dbg
);

    // Handshake: a request is accepted on a rising edge in IDLE with rdy_in=1;
    // ack_out is high for the cycle after that edge, and rdy_out is high for
    // one cycle when dataout/esito become valid. rdy_in is ignored elsewhere.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MEM  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_PUSH  = 3'd0;
    localparam logic [2:0] OP_POP   = 3'd1;
    localparam logic [2:0] OP_TOP   = 3'd2;
    localparam logic [2:0] OP_PEEK  = 3'd3;
    localparam logic [2:0] OP_SIZE  = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    state_t state, state_nxt;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [AW-1:0]    n_q;
    logic [AW:0]      sp;

    logic             err_q;
    logic             rd_sel_q;
    logic [WIDTH-1:0] res_q;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    logic             err;
    logic             mem_we;
    logic             mem_re;
    logic [AW-1:0]    addr;
    logic [AW:0]      sp_nxt;
    logic [WIDTH-1:0] res;
    logic [WIDTH+AW:0] size_ext;

    assign full      = (sp == SP_FULL);
    assign empty     = (sp == '0);
    assign state_dbg = state;
    // SIZE returns the low WIDTH bits of the zero-extended pointer.
    assign size_ext  = {{WIDTH{1'b0}}, sp};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (rdy_in) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_MEM;
            S_MEM:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operation decode; only acts while in EXEC.
    always_comb begin
        err    = 1'b0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        addr   = '0;
        sp_nxt = sp;
        res    = '0;
        if (state == S_EXEC) begin
            case (op_q)
                OP_PUSH: begin
                    if (full) begin
                        err = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        addr   = sp[AW-1:0];
                        sp_nxt = sp + SP_ONE;
                        res    = data_q;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        err = 1'b1;
                    end else begin
                        mem_re = 1'b1;
                        addr   = sp[AW-1:0] - IDX_ONE;
                        sp_nxt = sp - SP_ONE;
                    end
                end
                OP_TOP: begin
                    if (empty) begin
                        err = 1'b1;
                    end else begin
                        mem_re = 1'b1;
                        addr   = sp[AW-1:0] - IDX_ONE;
                    end
                end
                OP_PEEK: begin
                    if ({1'b0, n_q} >= sp) begin
                        err = 1'b1;
                    end else begin
                        mem_re = 1'b1;
                        addr   = sp[AW-1:0] - IDX_ONE - n_q;
                    end
                end
                OP_SIZE:  res = size_ext[WIDTH-1:0];
                OP_CLEAR: sp_nxt = '0;
                default:  err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp       <= '0;
            ack_out  <= 1'b0;
            rdy_out  <= 1'b0;
            dataout  <= '0;
            esito    <= 1'b0;
            op_q     <= '0;
            data_q   <= '0;
            n_q      <= '0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
            res_q    <= '0;
        end else begin
            ack_out <= (state == S_IDLE) && rdy_in;
            rdy_out <= (state == S_MEM);
            if ((state == S_IDLE) && rdy_in) begin
                op_q   <= op;
                data_q <= datain;
                n_q    <= n;
            end
            if (state == S_EXEC) begin
                sp       <= sp_nxt;
                err_q    <= err;
                rd_sel_q <= mem_re;
                res_q    <= res;
            end
            if (state == S_MEM) begin
                esito   <= ~err_q;
                dataout <= err_q ? '0 : (rd_sel_q ? rd_q : res_q);
            end
        end
    end

    // Storage is not reset; writes only happen in EXEC, which reset leaves.
    always_ff @(posedge clock) begin
        if (mem_we) mem[addr] <= data_q;
        if (mem_re) rd_q <= mem[addr];
    end

endmodule

// File: tb/tb_stack_unit_param.sv
// Directed bench for stack_unit_param: a 1024-deep instance for the main
// sequences and a 4-deep instance for full/empty bounds.
module tb_stack_unit_param;

    localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, TOP = 3'd2, PEEK = 3'd3;
    localparam logic [2:0] SIZE = 3'd4, CLEAR = 3'd5;

    logic        clock = 1'b0;
    logic        reset;
    logic        rdy_b, rdy_s;
    logic [2:0]  op_in;
    logic [31:0] datain;
    logic [9:0]  n_in;

    logic        ack_b, rdyo_b, es_b, full_b, empty_b;
    logic [31:0] dout_b;
    logic [1:0]  st_b;
    logic        ack_s, rdyo_s, es_s, full_s, empty_s;
    logic [31:0] dout_s;
    logic [1:0]  st_s;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    stack_unit_param #(.WIDTH(32), .DEPTH(1024)) u_big (
        .clock(clock), .reset(reset), .rdy_in(rdy_b), .op(op_in),
        .datain(datain), .n(n_in), .ack_out(ack_b), .rdy_out(rdyo_b),
        .dataout(dout_b), .esito(es_b), .full(full_b), .empty(empty_b),
        .state_dbg(st_b)
    );

    stack_unit_param #(.WIDTH(32), .DEPTH(4)) u_small (
        .clock(clock), .reset(reset), .rdy_in(rdy_s), .op(op_in),
        .datain(datain), .n(n_in[1:0]), .ack_out(ack_s), .rdy_out(rdyo_s),
        .dataout(dout_s), .esito(es_s), .full(full_s), .empty(empty_s),
        .state_dbg(st_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for its result; lat counts negedges from the ack sample to rdy_out.
    task automatic req(input bit sel, input logic [2:0] o, input logic [31:0] d,
                       input logic [9:0] nn, output logic [31:0] dout, output logic es,
                       output int lat);
        bit got;
        @(negedge clock);
        op_in = o; datain = d; n_in = nn;
        if (sel) rdy_s = 1'b1; else rdy_b = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge clock); #1;
            got = sel ? ack_s : ack_b;
        end
        rdy_s = 1'b0; rdy_b = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
        got = 1'b0; lat = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clock);
            lat++;
            got = sel ? rdyo_s : rdyo_b;
        end
        check("rdy_out_seen", 32'(got), 32'd1);
        dout = sel ? dout_s : dout_b;
        es   = sel ? es_s : es_b;
    endtask

    task automatic run(input bit sel, input logic [2:0] o, input logic [31:0] d,
                       input logic [9:0] nn, input string tag,
                       input logic [31:0] exp_d, input logic exp_es);
        logic [31:0] dout;
        logic es;
        int lat;
        req(sel, o, d, nn, dout, es, lat);
        check({tag, "_dout"}, dout, exp_d);
        check({tag, "_esito"}, 32'(es), 32'(exp_es));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, pulses, cyc, last_ack, extra, lat;
        logic [31:0] d;
        logic es;

        reset = 1'b1; rdy_b = 1'b0; rdy_s = 1'b0;
        op_in = '0; datain = '0; n_in = '0;
        repeat (2) @(negedge clock);
        check("rst_state", 32'(st_b), 32'd0);
        check("rst_ack", 32'(ack_b), 32'd0);
        check("rst_rdy_out", 32'(rdyo_b), 32'd0);
        check("rst_dout", dout_b, 32'd0);
        check("rst_esito", 32'(es_b), 32'd0);
        check("rst_empty", 32'(empty_b), 32'd1);
        check("rst_full", 32'(full_b), 32'd0);
        check("rst_small_empty", 32'(empty_s), 32'd1);
        check("rst_small_full", 32'(full_s), 32'd0);
        reset = 1'b0;

        // T1: push stream with rdy_in held high.
        @(negedge clock);
        op_in = PUSH; datain = 32'd1023; rdy_b = 1'b1;
        acks = 0; pulses = 0; cyc = 0; last_ack = 0;
        while (pulses < 5 && cyc < 60) begin
            @(posedge clock); #1;
            cyc++;
            if (ack_b) begin
                if (acks > 0) check("t1_ack_spacing", 32'(cyc - last_ack), 32'd4);
                last_ack = cyc;
                acks++;
                if (acks == 5) rdy_b = 1'b0;
                datain = 32'(1023 - acks);
            end
            if (rdyo_b) begin
                check("t1_dout", dout_b, 32'(1023 - pulses));
                check("t1_esito", 32'(es_b), 32'd1);
                pulses++;
            end
        end
        rdy_b = 1'b0;
        check("t1_pulses", 32'(pulses), 32'd5);
        run(0, SIZE, 0, 0, "t1_size", 32'd5, 1'b1);

        // T2: top/pop.
        run(0, TOP, 0, 0, "t2_top", 32'd1019, 1'b1);
        run(0, SIZE, 0, 0, "t2_size5", 32'd5, 1'b1);
        run(0, POP, 0, 0, "t2_pop1", 32'd1019, 1'b1);
        run(0, POP, 0, 0, "t2_pop2", 32'd1020, 1'b1);
        run(0, SIZE, 0, 0, "t2_size3", 32'd3, 1'b1);

        // T3: peek.
        run(0, CLEAR, 32'hffff, 0, "t3_clear", 32'd0, 1'b1);
        run(0, PUSH, 32'd10, 0, "t3_push10", 32'd10, 1'b1);
        run(0, PUSH, 32'd20, 0, "t3_push20", 32'd20, 1'b1);
        run(0, PUSH, 32'd30, 0, "t3_push30", 32'd30, 1'b1);
        run(0, PEEK, 0, 10'd0, "t3_peek0", 32'd30, 1'b1);
        run(0, PEEK, 0, 10'd1, "t3_peek1", 32'd20, 1'b1);
        run(0, PEEK, 0, 10'd2, "t3_peek2", 32'd10, 1'b1);
        run(0, PEEK, 0, 10'd3, "t3_peek3", 32'd0, 1'b0);
        run(0, SIZE, 0, 0, "t3_size", 32'd3, 1'b1);

        // T4: bounds on the 4-deep instance.
        run(1, PUSH, 32'ha1, 0, "t4_push1", 32'ha1, 1'b1);
        run(1, PUSH, 32'ha2, 0, "t4_push2", 32'ha2, 1'b1);
        run(1, PUSH, 32'ha3, 0, "t4_push3", 32'ha3, 1'b1);
        check("t4_not_full", 32'(full_s), 32'd0);
        run(1, PUSH, 32'ha4, 0, "t4_push4", 32'ha4, 1'b1);
        check("t4_full", 32'(full_s), 32'd1);
        run(1, PUSH, 32'ha5, 0, "t4_push5", 32'd0, 1'b0);
        check("t4_full_kept", 32'(full_s), 32'd1);
        run(1, SIZE, 0, 0, "t4_size4", 32'd4, 1'b1);
        run(1, TOP, 0, 0, "t4_top", 32'ha4, 1'b1);
        run(1, POP, 0, 0, "t4_pop4", 32'ha4, 1'b1);
        run(1, POP, 0, 0, "t4_pop3", 32'ha3, 1'b1);
        run(1, POP, 0, 0, "t4_pop2", 32'ha2, 1'b1);
        run(1, POP, 0, 0, "t4_pop1", 32'ha1, 1'b1);
        check("t4_empty", 32'(empty_s), 32'd1);
        run(1, POP, 0, 0, "t4_pop_empty", 32'd0, 1'b0);
        check("t4_empty_kept", 32'(empty_s), 32'd1);
        run(1, TOP, 0, 0, "t4_top_empty", 32'd0, 1'b0);
        run(1, SIZE, 0, 0, "t4_size0", 32'd0, 1'b1);

        // T5: latency, busy-time rdy_in pulse, reserved ops.
        req(0, SIZE, 0, 0, d, es, lat);
        check("t5_latency", 32'(lat), 32'd3);
        check("t5_size", d, 32'd3);
        @(negedge clock);
        op_in = SIZE; rdy_b = 1'b1;
        acks = 0;
        for (int i = 0; i < 12 && acks == 0; i++) begin
            @(posedge clock); #1;
            if (ack_b) acks = 1;
        end
        rdy_b = 1'b0;
        check("t5_ack", 32'(acks), 32'd1);
        @(negedge clock);
        op_in = PUSH; datain = 32'hdead; rdy_b = 1'b1;
        @(negedge clock);
        rdy_b = 1'b0;
        extra = 0; pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (ack_b) extra++;
            if (rdyo_b) begin
                pulses++;
                check("t5_busy_size", dout_b, 32'd3);
            end
        end
        check("t5_busy_ignored", 32'(extra), 32'd0);
        check("t5_busy_one_result", 32'(pulses), 32'd1);
        run(0, 3'd6, 32'h1234, 0, "t5_op6", 32'd0, 1'b0);
        run(0, 3'd7, 32'h1234, 0, "t5_op7", 32'd0, 1'b0);
        run(0, SIZE, 0, 0, "t5_size_after", 32'd3, 1'b1);
        run(0, TOP, 0, 0, "t5_top_after", 32'd30, 1'b1);

        // T6: reset during the EXEC cycle of a PUSH.
        run(0, CLEAR, 0, 0, "t6_clear", 32'd0, 1'b1);
        run(0, PUSH, 32'd1, 0, "t6_push1", 32'd1, 1'b1);
        run(0, PUSH, 32'd2, 0, "t6_push2", 32'd2, 1'b1);
        @(negedge clock);
        op_in = PUSH; datain = 32'd3; rdy_b = 1'b1;
        acks = 0;
        for (int i = 0; i < 12 && acks == 0; i++) begin
            @(posedge clock); #1;
            if (ack_b) acks = 1;
        end
        rdy_b = 1'b0;
        check("t6_ack", 32'(acks), 32'd1);
        check("t6_in_exec", 32'(st_b), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_state", 32'(st_b), 32'd0);
        check("t6_ack_out", 32'(ack_b), 32'd0);
        check("t6_rdy_out", 32'(rdyo_b), 32'd0);
        check("t6_dout", dout_b, 32'd0);
        check("t6_esito", 32'(es_b), 32'd0);
        check("t6_empty", 32'(empty_b), 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run(0, SIZE, 0, 0, "t6_size", 32'd0, 1'b1);
        run(0, CLEAR, 0, 0, "t6_clear_after", 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
